// File: rtl/muldiv_pkg.sv
// Shared op encoding, FSM states and operand-class helpers for the iterative mul/div unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_datapath.sv
// One radix-2 step on the {acc, shreg} pair: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_iter_datapath #(
    parameter int unsigned XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] shreg,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] acc_nxt_c,
    output logic [XLEN-1:0] shreg_nxt_c
);

    logic [XLEN:0]   sum_c;
    logic [XLEN:0]   shifted_c;
    logic [XLEN-1:0] diff_c;
    logic            ge_c;

    always_comb begin
        sum_c       = {1'b0, acc};
        shifted_c   = {acc, shreg[XLEN-1]};
        ge_c        = (shifted_c >= {1'b0, opnd});
        // remainder after a successful subtract is below opnd, so the low XLEN bits are exact
        diff_c      = shifted_c[XLEN-1:0] - opnd;
        acc_nxt_c   = '0;
        shreg_nxt_c = '0;
        if (is_div) begin
            acc_nxt_c   = ge_c ? diff_c : shifted_c[XLEN-1:0];
            shreg_nxt_c = {shreg[XLEN-2:0], ge_c};
        end else begin
            if (shreg[0]) begin
                sum_c = {1'b0, acc} + {1'b0, opnd};
            end
            acc_nxt_c   = sum_c[XLEN:1];
            shreg_nxt_c = {sum_c[0], shreg[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude datapath over XLEN steps, then a sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy
);
    import muldiv_pkg::*;

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   acc, shreg, opnd;
    logic [XLEN-1:0]   acc_step_c, shreg_step_c;
    logic [2:0]        op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_res, neg_rem;

    logic              sign_a_c, sign_b_c, div0_c, ovf_c;
    logic [XLEN-1:0]   mag_a_c, mag_b_c, fix_c;
    logic [2*XLEN-1:0] prod_fix_c;

    muldiv_iter_datapath #(.XLEN(XLEN)) u_step (
        .is_div      (is_div(op_q)),
        .acc         (acc),
        .shreg       (shreg),
        .opnd        (opnd),
        .acc_nxt_c   (acc_step_c),
        .shreg_nxt_c (shreg_step_c)
    );

    // Operand classification at the accepting edge
    always_comb begin
        sign_a_c = is_signed_a(op) & src_a[XLEN-1];
        sign_b_c = is_signed_b(op) & src_b[XLEN-1];
        mag_a_c  = sign_a_c ? -src_a : src_a;
        mag_b_c  = sign_b_c ? -src_b : src_b;
        div0_c   = is_div(op) && (src_b == '0);
        ovf_c    = is_div(op) && is_signed_a(op) && (src_a == MOST_NEG) && (src_b == '1);
    end

    // Sign correction and half/quotient/remainder select
    always_comb begin
        prod_fix_c = neg_res ? -{acc, shreg} : {acc, shreg};
        fix_c      = '0;
        if (is_div(op_q)) begin
            if ((op_q == OP_DIV) || (op_q == OP_DIVU)) fix_c = neg_res ? -shreg : shreg;
            else                                       fix_c = neg_rem ? -acc : acc;
        end else if (op_q == OP_MUL) begin
            fix_c = prod_fix_c[XLEN-1:0];
        end else begin
            fix_c = prod_fix_c[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid) state_nxt = (div0_c || ovf_c) ? S_FIX : S_CALC;
            S_CALC: if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == S_DONE);
            busy      <= (state_nxt != S_IDLE);
            in_ready  <= (state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            shreg   <= '0;
            opnd    <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            result  <= '0;
            tag_out <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    op_q  <= op;
                    tag_q <= tag_in;
                    opnd  <= mag_b_c;
                    cnt   <= '0;
                    // Fast-path results are preloaded so the fix stage passes them through unchanged
                    if (div0_c) begin
                        acc     <= src_a;
                        shreg   <= '1;
                        neg_res <= 1'b0;
                        neg_rem <= 1'b0;
                    end else if (ovf_c) begin
                        acc     <= '0;
                        shreg   <= src_a;
                        neg_res <= 1'b0;
                        neg_rem <= 1'b0;
                    end else begin
                        acc     <= '0;
                        shreg   <= mag_a_c;
                        neg_res <= sign_a_c ^ sign_b_c;
                        neg_rem <= sign_a_c;
                    end
                end
                S_CALC: begin
                    acc   <= acc_step_c;
                    shreg <= shreg_step_c;
                    cnt   <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    result  <= fix_c;
                    tag_out <= tag_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [XLEN-1:0]  src_a, src_b;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] u;
        longint      s;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin s = longint'($signed(a)) * longint'($signed(b)); u = 64'(s); return u[63:32]; end
            3'd2: begin s = longint'($signed(a)) * longint'({32'd0, b}); u = 64'(s); return u[63:32]; end
            3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_edge(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return XLEN + 2;
    endfunction

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        op = f3; src_a = a; src_b = b; tag_in = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edge numbering counts the accepting edge as edge 1
    task automatic wait_valid(output int edge_n, output logic ready_low);
        edge_n = 1; ready_low = 1'b1;
        while (out_valid !== 1'b1 && edge_n < 200) begin
            if (in_ready !== 1'b0) ready_low = 1'b0;
            @(posedge clk); #1;
            edge_n++;
        end
        if (in_ready !== 1'b0) ready_low = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
        int e; logic rl;
        start_op(f3, a, b, t);
        wait_valid(e, rl);
        check({name, " edge"}, 32'(e), 32'(ref_edge(f3, a, b)));
        check({name, " result"}, result, ref_result(f3, a, b));
        check({name, " tag"}, 32'(tag_out), 32'(t));
        check({name, " in_ready low"}, 32'(rl), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, " drained"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int e; logic rl;
        logic [2:0] rop; logic [31:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; src_a = '0; src_b = '0;
        tag_in = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("reset flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check("reset result", result, 32'd0);
        check("reset tag", 32'(tag_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
        do_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
        do_op("divu", 3'd5, 32'd100, 32'd7, 5'd7);
        do_op("remu", 3'd7, 32'd100, 32'd7, 5'd8);
        do_op("divu0", 3'd5, 32'd5, 32'd0, 5'd9);
        do_op("remu0", 3'd7, 32'd5, 32'd0, 5'd10);
        do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

        // Abort during iteration 10, then immediately reuse the unit
        start_op(3'd0, 32'd12345, 32'd678, 5'd13);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("flush calc", {29'd0, out_valid, busy, in_ready}, 32'd1);
        do_op("post flush", 3'd0, 32'd3, 32'd4, 5'd14);

        // Request coincident with flush in IDLE is dropped
        op = 3'd0; src_a = 32'd2; src_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        check("flush idle", {29'd0, out_valid, busy, in_ready}, 32'd1);

        // Backpressure in DONE: outputs hold, new requests ignored
        start_op(3'd0, 32'd5, 32'd6, 5'd21);
        wait_valid(e, rl);
        for (int i = 0; i < 5; i++) begin
            op = 3'd5; src_a = 32'(i + 50); src_b = 32'd3; tag_in = 5'd2; in_valid = 1'(i % 2);
            @(posedge clk); #1;
            check("hold result", result, 32'd30);
            check("hold tag", 32'(tag_out), 32'd21);
            check("hold valid", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        check("hold drained", {30'd0, out_valid, in_ready}, 32'd1);

        // Flush in DONE wins over a coincident out_ready
        start_op(3'd7, 32'd77, 32'd10, 5'd22);
        wait_valid(e, rl);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b0; out_ready = 1'b0;
        check("flush done", {29'd0, out_valid, busy, in_ready}, 32'd1);

        // Asynchronous reset mid-iteration
        start_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd23);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
        check("async rst result", result, 32'd0);
        check("async rst tag", 32'(tag_out), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post rst", 3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd24);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            do_op("random", rop, ra, rb, 5'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
